// File: rtl/rpn_evaluator.sv
`default_nettype none
// ==========================================================================
// rpn_evaluator : evaluates a postfix token stream on a value stack  rev 1.0
// ==========================================================================
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20,
  parameter int PTR_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_stb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_is_operator,
  output logic             in_ack,
  output logic             result_stb,
  output logic [WIDTH-1:0] result_data,
  output logic             result_err,
  input  logic             result_ack,
  output logic [PTR_W-1:0] stack_level
);

  localparam logic [2:0]       OP_MUL = 3'b001;
  localparam logic [2:0]       OP_ADD = 3'b010;
  localparam logic [2:0]       OP_SUB = 3'b011;
  localparam logic [2:0]       OP_EQ  = 3'b100;
  localparam logic [PTR_W-1:0] FULL   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO    = PTR_W'(2);

  typedef enum logic [2:0] {IDLE, EXEC, RES, WAIT_R, ACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [PTR_W-1:0] level;
  logic             err;
  logic [2:0]       op;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] nxt_idx;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] nxt_val;
  logic [WIDTH-1:0] alu_out;
  logic             push_en;
  logic             exec_en;

  // Indices are clamped so an empty or single-entry stack never reads out of range
  always_comb begin
    top_idx = (level >= ONE) ? level - ONE : '0;
    nxt_idx = (level >= TWO) ? level - TWO : '0;
  end

  assign top_val     = stack[top_idx];
  assign nxt_val     = stack[nxt_idx];
  assign stack_level = level;

  always_comb begin
    case (op)
      OP_MUL:  alu_out = nxt_val * top_val;
      OP_ADD:  alu_out = nxt_val + top_val;
      default: alu_out = nxt_val - top_val;
    endcase
  end

  assign push_en = (state == IDLE) && in_stb && !in_is_operator && (level != FULL);
  assign exec_en = (state == EXEC) && (level >= TWO);

  // Stack storage carries no reset: the level register alone defines validity
  always_ff @(posedge CLK) begin
    if (push_en)
      stack[level] <= in_data;
    else if (exec_en)
      stack[nxt_idx] <= alu_out;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      in_ack      <= 1'b0;
      result_stb  <= 1'b0;
      result_data <= '0;
      result_err  <= 1'b0;
      level       <= '0;
      err         <= 1'b0;
      op          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_stb) begin
            if (!in_is_operator) begin
              if (level == FULL) err   <= 1'b1;
              else               level <= level + ONE;
              in_ack <= 1'b1;
              state  <= ACK;
            end else begin
              op <= in_data[2:0];
              case (in_data[2:0])
                OP_MUL, OP_ADD, OP_SUB: state <= EXEC;
                OP_EQ:                  state <= RES;
                default: begin
                  err    <= 1'b1;
                  in_ack <= 1'b1;
                  state  <= ACK;
                end
              endcase
            end
          end
        end
        EXEC: begin
          if (level >= TWO) level <= level - ONE;
          else              err   <= 1'b1;
          in_ack <= 1'b1;
          state  <= ACK;
        end
        RES: begin
          if ((level == ONE) && !err) begin
            result_data <= top_val;
            result_err  <= 1'b0;
          end else begin
            result_data <= '0;
            result_err  <= 1'b1;
          end
          result_stb <= 1'b1;
          state      <= WAIT_R;
        end
        WAIT_R: begin
          if (result_ack) begin
            result_stb <= 1'b0;
            result_err <= 1'b0;
            level      <= '0;
            err        <= 1'b0;
            in_ack     <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          in_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
